// File: rtl/evm_tally_core.sv
// evm_tally_core: parametrised vote-tally engine. Counts votes per candidate with
// saturating counters, enforces a cooldown after each accepted vote, and scans for the
// winner (lowest index among equal maxima) one candidate per cycle after the poll closes.
module evm_tally_core #(
    parameter int unsigned N_CAND   = 4,
    parameter int unsigned CNT_W    = 8,
    parameter int unsigned LOCK_CYC = 4,
    localparam int unsigned SEL_W   = $clog2(N_CAND),
    localparam int unsigned TOT_W   = CNT_W + SEL_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             poll_open,
    input  logic             poll_close,
    input  logic             vote_valid,
    input  logic [SEL_W-1:0] vote_sel,
    input  logic [SEL_W-1:0] rd_idx,
    output logic             vote_ack,
    output logic             vote_rej,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] rd_count,
    output logic [TOT_W-1:0] total,
    output logic [SEL_W-1:0] winner,
    output logic             tie,
    output logic             res_valid,
    output logic             sat
);

    localparam int unsigned LOCK_W = (LOCK_CYC > 1) ? $clog2(LOCK_CYC) : 1;

    localparam logic [SEL_W:0]    N_CAND_W  = (SEL_W + 1)'(N_CAND);
    localparam logic [SEL_W-1:0]  LAST_IDX  = SEL_W'(N_CAND - 1);
    localparam logic [SEL_W-1:0]  SEL_ONE   = SEL_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;
    localparam logic [TOT_W-1:0]  TOT_ONE   = TOT_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_ONE  = LOCK_W'(1);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCK_CYC - 1);

    typedef enum logic [2:0] {
        StIdle,
        StOpen,
        StLock,
        StTally,
        StDone
    } fsm_e;

    fsm_e              fsm_q;
    logic [CNT_W-1:0]  cnt_q [N_CAND];
    logic [CNT_W-1:0]  best_q;
    logic [SEL_W-1:0]  scan_q;
    logic [LOCK_W-1:0] lock_q;

    logic              sel_ok;
    logic              rd_ok;
    logic [CNT_W-1:0]  sel_cnt;
    logic [CNT_W-1:0]  scan_cnt;

    // Decode the addressed counters; out-of-range indices read as zero.
    always_comb begin
        sel_ok   = ({1'b0, vote_sel} < N_CAND_W);
        rd_ok    = ({1'b0, rd_idx} < N_CAND_W);
        sel_cnt  = '0;
        if (sel_ok) begin
            sel_cnt = cnt_q[vote_sel];
        end
        scan_cnt = cnt_q[scan_q];
    end

    // Report TALLY and DONE with the same code; res_valid tells them apart.
    always_comb begin
        case (fsm_q)
            StIdle:  state = 2'd0;
            StOpen:  state = 2'd1;
            StLock:  state = 2'd2;
            default: state = 2'd3;
        endcase
    end

    // Poll FSM, vote counting, lockout and winner scan.
    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q     <= StIdle;
            for (int unsigned i = 0; i < N_CAND; i++) begin
                cnt_q[i] <= '0;
            end
            total     <= '0;
            winner    <= '0;
            tie       <= 1'b0;
            res_valid <= 1'b0;
            sat       <= 1'b0;
            vote_ack  <= 1'b0;
            vote_rej  <= 1'b0;
            best_q    <= '0;
            scan_q    <= '0;
            lock_q    <= '0;
        end else begin
            vote_ack <= 1'b0;
            vote_rej <= 1'b0;
            case (fsm_q)
                StIdle, StDone: begin
                    vote_rej <= vote_valid;
                    if (poll_open) begin
                        for (int unsigned i = 0; i < N_CAND; i++) begin
                            cnt_q[i] <= '0;
                        end
                        total     <= '0;
                        sat       <= 1'b0;
                        res_valid <= 1'b0;
                        winner    <= '0;
                        tie       <= 1'b0;
                        fsm_q     <= StOpen;
                    end
                end
                StOpen: begin
                    if (poll_close) begin
                        // Close beats a simultaneous vote.
                        vote_rej <= vote_valid;
                        scan_q   <= '0;
                        fsm_q    <= StTally;
                    end else if (vote_valid) begin
                        if (!sel_ok) begin
                            vote_rej <= 1'b1;
                        end else if (sel_cnt == CNT_MAX) begin
                            vote_rej <= 1'b1;
                            sat      <= 1'b1;
                        end else begin
                            cnt_q[vote_sel] <= sel_cnt + CNT_ONE;
                            total           <= total + TOT_ONE;
                            vote_ack        <= 1'b1;
                            lock_q          <= LOCK_LOAD;
                            fsm_q           <= StLock;
                        end
                    end
                end
                StLock: begin
                    vote_rej <= vote_valid;
                    if (poll_close) begin
                        scan_q <= '0;
                        fsm_q  <= StTally;
                    end else if (lock_q == '0) begin
                        fsm_q <= StOpen;
                    end else begin
                        lock_q <= lock_q - LOCK_ONE;
                    end
                end
                StTally: begin
                    vote_rej <= vote_valid;
                    // Index 0 seeds the running max; later indices need a strict win.
                    if (scan_q == '0 || scan_cnt > best_q) begin
                        best_q <= scan_cnt;
                        winner <= scan_q;
                        tie    <= 1'b0;
                    end else if (scan_cnt == best_q) begin
                        tie <= 1'b1;
                    end
                    if (scan_q == LAST_IDX) begin
                        res_valid <= 1'b1;
                        fsm_q     <= StDone;
                    end else begin
                        scan_q <= scan_q + SEL_ONE;
                    end
                end
                default: fsm_q <= StIdle;
            endcase
        end
    end

    // Registered readout port.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_count <= '0;
        end else if (rd_ok) begin
            rd_count <= cnt_q[rd_idx];
        end else begin
            rd_count <= '0;
        end
    end

endmodule
